// File: rtl/ann_pkg.sv
// Shared constants and state encoding for the ANN MAC result serializer.
package ann_pkg;

    localparam int ANN_MAC_W = 32;
    localparam int ANN_N_MAC = 20;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } annState_t;

endpackage

// File: rtl/ann_mux_nto1.sv
// Combinational N-to-1 word select from a flattened bank; an index beyond
// the last channel falls back to channel N_CH-1.
module ann_mux_nto1 #(
    parameter int N_CH   = 20,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic [N_CH*DATA_W-1:0] iBank,
    input  logic [IDX_W-1:0]       iSel,
    output logic [DATA_W-1:0]      oData
);

    // Word select with last-channel fallback
    always_comb begin
        oData = iBank[(N_CH-1)*DATA_W +: DATA_W];
        for (int k = 0; k < N_CH; k++) begin
            if (iSel == IDX_W'(k)) begin
                oData = iBank[k*DATA_W +: DATA_W];
            end else begin
                oData = oData;
            end
        end
    end

endmodule

// File: rtl/ann_mac_serializer.sv
// Snapshots N_CH MAC results on a load request and streams them out one word
// per accepted handshake, with burst-length control and an overrun flag.
module ann_mac_serializer
    import ann_pkg::*;
#(
    parameter int N_CH   = ANN_N_MAC,
    parameter int DATA_W = ANN_MAC_W,
    parameter int IDX_W  = 5
) (
    input  logic                   iClk,
    input  logic                   iReset,
    input  logic [N_CH*DATA_W-1:0] iMac,
    input  logic                   iLoad,
    input  logic [IDX_W:0]         iNum,
    input  logic                   iReady,
    output logic [DATA_W-1:0]      oData_out,
    output logic [IDX_W-1:0]       oIdx,
    output logic                   oValid,
    output logic                   oLast,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oOverrun
);

    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(N_CH);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   CNT_ZERO = (IDX_W+1)'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    annState_t             stateR;
    annState_t             stateNextS;
    logic [IDX_W-1:0]      idxR;
    logic [IDX_W-1:0]      idxNextS;
    logic [IDX_W:0]        countR;
    logic [N_CH*DATA_W-1:0] snapR;
    logic                  doneR;
    logic                  overrunR;
    logic                  sendS;
    logic                  lastS;
    logic                  loadAcceptS;
    logic [DATA_W-1:0]     muxDataS;

    // Out-of-range requests (0 or more than N_CH) mean "emit every channel".
    function automatic logic [IDX_W:0] effCount(input logic [IDX_W:0] num);
        if ((num == CNT_ZERO) || (num > CNT_FULL)) begin
            return CNT_FULL;
        end else begin
            return num;
        end
    endfunction

    assign sendS       = (stateR == ST_SEND);
    assign lastS       = sendS && ({1'b0, idxR} == (countR - CNT_ONE));
    assign loadAcceptS = (stateR == ST_IDLE) && iLoad;

    // Next-state and index sequencing
    always_comb begin
        stateNextS = stateR;
        idxNextS   = idxR;
        case (stateR)
            ST_IDLE: begin
                if (iLoad) begin
                    stateNextS = ST_SEND;
                    idxNextS   = IDX_ZERO;
                end else begin
                    stateNextS = ST_IDLE;
                    idxNextS   = IDX_ZERO;
                end
            end
            ST_SEND: begin
                if (iReady && lastS) begin
                    stateNextS = ST_IDLE;
                    idxNextS   = IDX_ZERO;
                end else if (iReady) begin
                    idxNextS   = idxR + IDX_ONE;
                end else begin
                    idxNextS   = idxR;
                end
            end
            default: begin
                stateNextS = ST_IDLE;
                idxNextS   = IDX_ZERO;
            end
        endcase
    end

    // State and index registers
    always_ff @(posedge iClk) begin
        if (iReset) begin
            stateR <= ST_IDLE;
            idxR   <= IDX_ZERO;
        end else begin
            stateR <= stateNextS;
            idxR   <= idxNextS;
        end
    end

    // Burst length, completion pulse and sticky overrun flag
    always_ff @(posedge iClk) begin
        if (iReset) begin
            countR   <= CNT_ZERO;
            doneR    <= 1'b0;
            overrunR <= 1'b0;
        end else begin
            doneR <= sendS && iReady && lastS;
            if (loadAcceptS) begin
                countR   <= effCount(iNum);
                overrunR <= 1'b0;
            end else if (sendS && iLoad) begin
                overrunR <= 1'b1;
            end
        end
    end

    // Snapshot bank; contents are only ever observed through the gated mux
    always_ff @(posedge iClk) begin
        if (loadAcceptS) begin
            snapR <= iMac;
        end
    end

    ann_mux_nto1 #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) uMux (
        .iBank (snapR),
        .iSel  (idxR),
        .oData (muxDataS)
    );

    assign oValid    = sendS;
    assign oBusy     = sendS;
    assign oLast     = lastS;
    assign oIdx      = sendS ? idxR : IDX_ZERO;
    assign oData_out = sendS ? muxDataS : {DATA_W{1'b0}};
    assign oDone     = doneR;
    assign oOverrun  = overrunR;

endmodule

// File: doc/ann_mac_serializer.md
ANN_MAC_SERIALIZER -- requirements
Module: ann_mac_serializer

Interface
REQ-001 Parameter N_CH, default 20, number of MAC channels (2..32).
REQ-002 Parameter DATA_W, default 32, width of one MAC result.
REQ-003 Parameter IDX_W, default 5, channel index width; SHALL satisfy 2**IDX_W >= N_CH.
REQ-004 iClk  input  1  single clock; all state updates on rising edge.
REQ-005 iReset  input  1  reset, synchronous, active-high.
REQ-006 iMac  input  N_CH*DATA_W  flattened MAC results; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 iLoad  input  1  one-cycle request to snapshot iMac and start emission.
REQ-008 iNum  input  IDX_W+1  number of channels to emit, sampled with iLoad.
REQ-009 iReady  input  1  downstream accepts the current word.
REQ-010 oData_out  output  DATA_W  current channel value.
REQ-011 oIdx  output  IDX_W  channel index of oData_out.
REQ-012 oValid  output  1  oData_out/oIdx valid.
REQ-013 oLast  output  1  current word is the final one of the burst.
REQ-014 oBusy  output  1  a burst is in progress.
REQ-015 oDone  output  1  one-cycle pulse after the final word is accepted.
REQ-016 oOverrun  output  1  sticky flag: iLoad arrived while busy.

Function
REQ-017 The block SHALL have states IDLE and SEND.
REQ-018 In IDLE with iLoad=1, the block SHALL register all N_CH words of iMac into a snapshot bank, register the emit count, set index to 0, and enter SEND on the next edge.
REQ-019 Emit count SHALL equal iNum when 1 <= iNum <= N_CH; iNum=0 or iNum>N_CH SHALL be treated as N_CH.
REQ-020 Latency: iLoad in cycle t SHALL give oValid=1 with channel 0 in cycle t+1.
REQ-021 In SEND, oValid SHALL be 1, oData_out SHALL equal snapshot[oIdx], oBusy SHALL be 1.
REQ-022 While oValid=1 and iReady=0, oData_out, oIdx, oLast SHALL hold stable.
REQ-023 oValid=1 and iReady=1 on a non-final word SHALL increment oIdx by 1 on the next edge.
REQ-024 oLast SHALL be 1 exactly when oIdx = emit count - 1 in SEND.
REQ-025 Acceptance of the final word SHALL return to IDLE and assert oDone for exactly the next cycle; oValid SHALL be 0 in that cycle.
REQ-026 In IDLE, oValid, oLast, oBusy SHALL be 0; oData_out and oIdx SHALL be 0.
REQ-027 iLoad in SEND SHALL be ignored for data and SHALL set oOverrun to 1; snapshot SHALL not change.
REQ-028 iLoad in the oDone cycle (state IDLE) SHALL be accepted as a new burst per REQ-018.
REQ-029 oOverrun SHALL clear only on reset or on an accepted iLoad in IDLE; set has priority over clear in the same cycle only if both cannot occur (they are mutually exclusive by state).
REQ-030 iMac changes after the snapshot SHALL not affect emitted data.
REQ-031 Throughput with iReady held 1 SHALL be one word per cycle; a full N_CH burst SHALL occupy N_CH cycles of oValid.

Reset
REQ-032 iReset=1 at an edge SHALL force IDLE, clear oIdx, emit count, oDone, oOverrun, and all outputs to 0, regardless of state, including mid-burst.
REQ-033 Snapshot bank contents need not reset; they SHALL never be visible while oValid=0.

Structure
REQ-034 Shared package ann_pkg SHALL hold ANN_MAC_W=32, ANN_N_MAC=20, and the state encoding constants.
REQ-035 One sub-module ann_mux_nto1 (parametrised N_CH/DATA_W combinational select of snapshot by oIdx) SHALL be used; out-of-range index SHALL select channel N_CH-1.

Verification
REQ-036 Load iMac[k]=k+100, iNum=0, iReady=1 -> words 100..119 on 20 consecutive cycles, oIdx 0..19, oLast on idx 19, oDone next cycle.
REQ-037 iNum=3, iReady toggling 1,0,1,0,1 -> only idx 0,1,2 emitted, each held during iReady=0, oDone after idx 2 acceptance.
REQ-038 iLoad again at idx 5 of a burst with new iMac -> burst continues with original data, oOverrun=1 until next accepted iLoad.
REQ-039 iReset at idx 7 -> next cycle oValid=0, oBusy=0, oIdx=0, oOverrun=0; subsequent iLoad starts at idx 0.
REQ-040 iLoad asserted in oDone cycle with iNum=25 -> new 20-word burst starts next cycle, no gap beyond the oDone cycle.
